box: RTL and testbench

BOX -- requirements
Module: box

---
 rtl/box_pkg.sv | 16 +
 rtl/box.sv | 43 ++++
 tb/tb_box.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/box_pkg.sv
// box_pkg: encoding shared by the box cell, the board and the victory logic.
//   box_val_t  - 2-bit box contents / box state: EMPTY=0, PLAYER_A=1, PLAYER_B=2
//   claim_owner - maps the claiming player bit (0 = A, 1 = B) to its owner code
package box_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PLAYER_A = 2'd1,
    PLAYER_B = 2'd2
  } box_val_t;

  function automatic box_val_t claim_owner(input logic player);
    return player ? PLAYER_B : PLAYER_A;
  endfunction

endpackage

// File: rtl/box.sv
// box: one cell of the game board. It is claimed once by the player presenting
// a select strobe while empty, and then holds that owner until reset.
//   clk       in  1  clock, rising edge
//   reset     in  1  synchronous active-high reset, forces EMPTY
//   select    in  1  claim strobe, already gated by the parent's address match
//   curPlayer in  1  claiming player: 0 = A, 1 = B
//   boxVal    out 2  box contents (box_val_t encoding), registered
module box
  import box_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       select,
  input  logic       curPlayer,
  output logic [1:0] boxVal
);

  box_val_t r_state;
  box_val_t w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Owned states are absorbing; the unused encoding falls back to EMPTY.
  always_comb begin
    w_next = EMPTY;
    case (r_state)
      EMPTY:    w_next = select ? claim_owner(curPlayer) : EMPTY;
      PLAYER_A: w_next = PLAYER_A;
      PLAYER_B: w_next = PLAYER_B;
      default:  w_next = EMPTY;
    endcase
  end

  // Output taken straight from the state register, no input-to-output path.
  assign boxVal = r_state;

endmodule

// File: tb/tb_box.sv
module tb_box;

  logic       clk;
  logic       reset;
  logic       select;
  logic       curPlayer;
  logic [1:0] boxVal;

  int unsigned errors;
  int unsigned checks;

  box dut (
    .clk      (clk),
    .reset    (reset),
    .select   (select),
    .curPlayer(curPlayer),
    .boxVal   (boxVal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sel;
    logic       cur;
    logic [1:0] exp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  // Monitor: every cycle boxVal is never 3 and only changes from 0 or via reset.
  logic       mon_en;
  logic       rst_at_edge;
  logic [1:0] prev_val;

  always @(posedge clk) rst_at_edge = reset;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (boxVal === 2'd3 || $isunknown(boxVal)) begin
        errors++;
        $display("FAIL monitor_legal: boxVal=%0d required 0..2", boxVal);
      end
      checks++;
      if (boxVal !== prev_val && prev_val !== 2'd0 && !rst_at_edge) begin
        errors++;
        $display("FAIL monitor_stable: boxVal changed %0d->%0d without reset",
                 prev_val, boxVal);
      end
    end
    prev_val = boxVal;
  end

  task automatic drive(input logic r, input logic s, input logic c);
    @(negedge clk);
    reset     = r;
    select    = s;
    curPlayer = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] exp);
    checks++;
    if (boxVal !== exp) begin
      errors++;
      $display("FAIL %s: boxVal=%0d required %0d", name, boxVal, exp);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    mon_en    = 1'b0;
    reset     = 1'b1;
    select    = 1'b0;
    curPlayer = 1'b0;

    //            rst   sel   cur   exp
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0};  // reset state
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0};  // gated select, curPlayer=1
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0};  // idle
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd2};  // B claims
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd2};  // held after select drops
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd2};  // A cannot overwrite
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd0};  // reset from B
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd1};  // A claims
    vecs[11] = '{1'b0, 1'b1, 1'b1, 2'd1};  // B cannot overwrite
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 2'd0};  // reset beats select
    vecs[14] = '{1'b0, 1'b1, 1'b1, 2'd2};  // first edge after reset claims
    vecs[15] = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 2'd0};  // reset held
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 2'd1};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 2'd0};

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].sel, vecs[i].cur);
      if (i == 0) mon_en = 1'b1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Multi-cycle select: only the first edge claims, later cycles ignored.
    drive(1'b0, 1'b1, 1'b1);
    check("hold_sel_first", 2'd2);
    drive(1'b0, 1'b1, 1'b0);
    check("hold_sel_second", 2'd2);
    drive(1'b0, 1'b1, 1'b0);
    check("hold_sel_third", 2'd2);

    // Reset with select held high throughout, then release.
    drive(1'b1, 1'b1, 1'b0);
    check("rst_sel_held", 2'd0);
    drive(1'b1, 1'b1, 1'b0);
    check("rst_sel_held2", 2'd0);
    drive(1'b0, 1'b1, 1'b0);
    check("release_claim_a", 2'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("idle_after_a", 2'd1);

    // Select=0 while empty never claims, whatever curPlayer does.
    drive(1'b1, 1'b0, 1'b0);
    check("rst_again", 2'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, k[0]);
      check($sformatf("empty_idle%0d", k), 2'd0);
    end
    drive(1'b0, 1'b1, 1'b0);
    check("late_claim_a", 2'd1);

    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
